hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter REG_SEL, default $clog2(NUM_REGS), register-index width.
REQ-003 SHALL have parameter MULDIV_LAT, default 4, EX occupancy in cycles of a mul/div op; legal range 2..16.
REQ-004 SHALL have the following ports:
- clk  input  1  clock; one clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_rs1, id_rs2  input  REG_SEL  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  input  1  ID instruction actually reads rs1/rs2.
- ex_rd  input  REG_SEL  destination of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_muldiv_start  input  1  EX instruction is mul/div; level, held while the instruction sits in EX.
- ex_branch_taken  input  1  EX resolved a taken branch or jump.
- pc_stall  output  1  hold PC.
- if_id_stall  output  1  hold IF/ID register.
- if_id_flush  output  1  clear IF/ID to NOP.
- id_ex_stall  output  1  hold ID/EX register.
- id_ex_flush  output  1  load bubble into ID/EX.
- ex_mem_bubble  output  1  load bubble into EX/MEM.
- busy  output  1  FSM in MULDIV state.
- stall_cycles  output  32  count of cycles with pc_stall=1.

Function
REQ-005 SHALL implement FSM states RUN and MULDIV, plus registers cnt (4 bits), md_done (1 bit) and stall_cycles.
REQ-006 SHALL detect load-use in RUN: ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-007 SHALL, on load-use in the same cycle, assert pc_stall, if_id_stall and id_ex_flush for exactly one cycle, combinationally, with no state change.
REQ-008 SHALL define muldiv trigger as ex_muldiv_start=1, state=RUN and md_done=0.
REQ-009 SHALL, on trigger, assert pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble in that cycle.
REQ-010 SHALL, on trigger with MULDIV_LAT>2, go to MULDIV with cnt=MULDIV_LAT-3.
REQ-011 SHALL, on trigger with MULDIV_LAT=2, stay in RUN and set md_done=1.
REQ-012 SHALL, in MULDIV, assert pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble and busy every cycle.
REQ-013 SHALL, in MULDIV, decrement cnt when cnt>0, and on cnt=0 go to RUN with md_done=1.
REQ-014 SHALL give total stall per mul/div op = MULDIV_LAT-1 consecutive cycles, so EX occupancy = MULDIV_LAT cycles.
REQ-015 SHALL clear md_done the cycle after it is set; md_done=1 suppresses re-trigger while the same op is still visible on ex_muldiv_start.
REQ-016 SHALL ignore ex_muldiv_start, ex_mem_read and ex_branch_taken while in MULDIV.
REQ-017 SHALL, on ex_branch_taken=1 in RUN, assert if_id_flush and id_ex_flush in that cycle, with no stall.
REQ-018 SHALL apply priority in RUN: branch > muldiv trigger > load-use; branch with load-use produces flushes only, pc_stall=0.
REQ-019 SHALL keep all control outputs 0 when no condition holds.
REQ-020 SHALL increment stall_cycles on every cycle with pc_stall=1, wrapping 0xFFFFFFFF->0.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, set state=RUN, cnt=0, md_done=0, stall_cycles=0, regardless of other inputs, including mid-MULDIV.
REQ-022 SHALL force pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble and busy to 0 while rst=1.

Verification
REQ-023 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cycles +1.
REQ-024 SHALL cover x0 / unused operand: ex_rd=0 or id_uses_rs1=0 with matching index -> no stall.
REQ-025 SHALL cover mul/div with MULDIV_LAT=4 and ex_muldiv_start held 4 cycles -> stall outputs high for exactly 3 cycles, busy high for 2, no re-trigger in cycle 4; stall_cycles +3.
REQ-026 SHALL cover simultaneous ex_branch_taken=1 and load-use -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-027 SHALL cover rst=1 asserted in the 2nd MULDIV cycle -> next cycle busy=0, all stalls 0, stall_cycles=0; a new ex_muldiv_start then triggers normally.
REQ-028 SHALL cover stall_cycles preloaded via forcing to 0xFFFFFFFF plus one stall cycle -> reads 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit
//  Description : Pipeline hazard controller. Resolves load-use interlocks,
//                multi-cycle mul/div occupancy of EX and taken-branch
//                flushes, and counts cycles in which the PC is held.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_control_unit #(
    parameter int NUM_REGS   = 32,
    parameter int REG_SEL    = $clog2(NUM_REGS),
    parameter int MULDIV_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_SEL-1:0] id_rs1,
    input  logic [REG_SEL-1:0] id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [REG_SEL-1:0] ex_rd,
    input  logic               ex_mem_read,
    input  logic               ex_muldiv_start,
    input  logic               ex_branch_taken,
    output logic               pc_stall,
    output logic               if_id_stall,
    output logic               if_id_flush,
    output logic               id_ex_stall,
    output logic               id_ex_flush,
    output logic               ex_mem_bubble,
    output logic               busy,
    output logic [31:0]        stall_cycles
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    // The trigger cycle and the final (cnt==0) MULDIV cycle both stall, so
    // MULDIV_LAT-1 stall cycles need the counter to start at MULDIV_LAT-3.
    localparam logic [3:0] CNT_INIT = (MULDIV_LAT > 2) ? 4'(MULDIV_LAT - 3) : 4'd0;
    localparam logic       LONG_OP  = (MULDIV_LAT > 2);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        md_done, md_done_next;

    logic        load_use;
    logic        md_trigger;

    // Hazard conditions seen by the instruction pair currently in ID/EX
    always_comb begin
        load_use   = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));
        md_trigger = ex_muldiv_start && (state == RUN) && !md_done;
    end

    // Next-state and control outputs; branch beats mul/div beats load-use
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        md_done_next  = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        busy          = 1'b0;

        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (md_trigger) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        id_ex_stall   = 1'b1;
                        ex_mem_bubble = 1'b1;
                        if (LONG_OP) begin
                            state_next = MULDIV;
                            cnt_next   = CNT_INIT;
                        end else begin
                            md_done_next = 1'b1;
                        end
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                MULDIV: begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_bubble = 1'b1;
                    busy          = 1'b1;
                    if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                    end else begin
                        state_next   = RUN;
                        md_done_next = 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State register; md_done is a one-cycle guard against re-triggering
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= 4'd0;
            md_done <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            md_done <= md_done_next;
        end
    end

    // Free-running count of PC-hold cycles, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (pc_stall) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control_unit
//  Description : Directed self-checking bench for hazard_control_unit
//                (MULDIV_LAT = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_control_unit;

    localparam int REG_SEL = 5;

    // Control vector order: {pc_stall, if_id_stall, if_id_flush,
    //                        id_ex_stall, id_ex_flush, ex_mem_bubble, busy}
    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_LDUSE  = 7'b1100100;
    localparam logic [6:0] C_MDTRIG = 7'b1101010;
    localparam logic [6:0] C_MDBUSY = 7'b1101011;
    localparam logic [6:0] C_BRANCH = 7'b0010100;

    logic               clk = 1'b0;
    logic               rst;
    logic [REG_SEL-1:0] id_rs1, id_rs2, ex_rd;
    logic               id_uses_rs1, id_uses_rs2;
    logic               ex_mem_read, ex_muldiv_start, ex_branch_taken;
    logic               pc_stall, if_id_stall, if_id_flush;
    logic               id_ex_stall, id_ex_flush, ex_mem_bubble, busy;
    logic [31:0]        stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_control_unit #(
        .NUM_REGS   (32),
        .REG_SEL    (REG_SEL),
        .MULDIV_LAT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_muldiv_start (ex_muldiv_start),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_bubble   (ex_mem_bubble),
        .busy            (busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    wire [6:0] ctl = {pc_stall, if_id_stall, if_id_flush,
                      id_ex_stall, id_ex_flush, ex_mem_bubble, busy};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, settle, then return
    task automatic apply(input logic r,
                         input logic [REG_SEL-1:0] rs1, input logic [REG_SEL-1:0] rs2,
                         input logic u1, input logic u2,
                         input logic [REG_SEL-1:0] rd,
                         input logic mr, input logic md, input logic br);
        @(negedge clk);
        rst             = r;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs1     = u1;
        id_uses_rs2     = u2;
        ex_rd           = rd;
        ex_mem_read     = mr;
        ex_muldiv_start = md;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_muldiv_start = 1'b0; ex_branch_taken = 1'b0;

        // Reset with hazards present: outputs forced low
        apply(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        check("rst_ctl", 32'(ctl), 32'(C_IDLE));
        apply(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        check("rst_ctl2", 32'(ctl), 32'(C_IDLE));
        idle();
        check("post_rst_ctl", 32'(ctl), 32'(C_IDLE));
        check("post_rst_cnt", stall_cycles, 32'd0);

        // Load-use through rs2
        apply(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("lduse_rs2", 32'(ctl), 32'(C_LDUSE));
        idle();
        check("lduse_rs2_after", 32'(ctl), 32'(C_IDLE));
        check("lduse_rs2_cnt", stall_cycles, 32'd1);

        // Load-use through rs1
        apply(1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        check("lduse_rs1", 32'(ctl), 32'(C_LDUSE));

        // x0 destination, unused operand, non-load: no stall
        apply(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        check("x0_nostall", 32'(ctl), 32'(C_IDLE));
        check("x0_cnt", stall_cycles, 32'd2);
        apply(1'b0, 5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        check("unused_rs1", 32'(ctl), 32'(C_IDLE));
        apply(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        check("not_load", 32'(ctl), 32'(C_IDLE));
        check("nostall_cnt", stall_cycles, 32'd2);

        // Mul/div held four cycles: three stall cycles, two busy, no re-trigger
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        check("md_c1", 32'(ctl), 32'(C_MDTRIG));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        check("md_c2", 32'(ctl), 32'(C_MDBUSY));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
        check("md_c3_ignores", 32'(ctl), 32'(C_MDBUSY));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        check("md_c4_noretrig", 32'(ctl), 32'(C_IDLE));
        idle();
        check("md_done_ctl", 32'(ctl), 32'(C_IDLE));
        check("md_cnt", stall_cycles, 32'd5);

        // Branch beats load-use and mul/div
        apply(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        check("br_lduse", 32'(ctl), 32'(C_BRANCH));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("br_md", 32'(ctl), 32'(C_BRANCH));
        idle();
        check("br_md_no_state", 32'(ctl), 32'(C_IDLE));
        check("br_cnt", stall_cycles, 32'd5);

        // Reset in the second MULDIV cycle
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rmd_c1", 32'(ctl), 32'(C_MDTRIG));
        apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rmd_rst_ctl", 32'(ctl), 32'(C_IDLE));
        idle();
        check("rmd_after_ctl", 32'(ctl), 32'(C_IDLE));
        check("rmd_after_cnt", stall_cycles, 32'd0);
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rmd_new_c1", 32'(ctl), 32'(C_MDTRIG));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rmd_new_c2", 32'(ctl), 32'(C_MDBUSY));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rmd_new_c3", 32'(ctl), 32'(C_MDBUSY));
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rmd_new_c4", 32'(ctl), 32'(C_IDLE));
        idle();
        check("rmd_new_cnt", stall_cycles, 32'd3);

        // Counter wrap
        @(negedge clk);
        force dut.stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles;
        rst = 1'b0; id_rs1 = 5'd6; id_rs2 = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
        ex_rd = 5'd6; ex_mem_read = 1'b1; ex_muldiv_start = 1'b0; ex_branch_taken = 1'b0;
        #1;
        check("wrap_pre", stall_cycles, 32'hFFFF_FFFF);
        check("wrap_ctl", 32'(ctl), 32'(C_LDUSE));
        idle();
        check("wrap_cnt", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
